// File: rtl/rx_medida_7o1_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_medida_7o1_if
// Description : Bundle between the 7O1 serial distance receiver and its
//               surroundings. The master side drives the serial line and
//               observes the decoded results. The slave side is the
//               receiver itself.
//   entrada_serial  serial line, idle high (master -> slave)
//   dado_recebido   last char accepted without error (7 bit)
//   pronto          1-cycle pulse, char accepted
//   medida          last valid frame, BCD {centena,dezena,unidade}
//   medida_valida   1-cycle pulse when medida updates
//   erro_paridade   1-cycle pulse, parity check failed
//   erro_quadro     1-cycle pulse, stop bit sampled low
//   erro_formato    1-cycle pulse, good char illegal for frame position
//   db_estado       {rx state, 1'b0} for 7-segment debug
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_medida_7o1_if;
    logic        entrada_serial;
    logic [6:0]  dado_recebido;
    logic        pronto;
    logic [11:0] medida;
    logic        medida_valida;
    logic        erro_paridade;
    logic        erro_quadro;
    logic        erro_formato;
    logic [3:0]  db_estado;

    modport master (
        output entrada_serial,
        input  dado_recebido, pronto, medida, medida_valida,
               erro_paridade, erro_quadro, erro_formato, db_estado
    );

    modport slave (
        input  entrada_serial,
        output dado_recebido, pronto, medida, medida_valida,
               erro_paridade, erro_quadro, erro_formato, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/rx_medida_7o1.sv
`default_nettype none
// ============================================================================
// Module      : rx_medida_7o1
// Description : Receiver for the 7O1 ASCII link (7 data bits LSB first, odd
//               parity, 1 stop). It deserialises characters and reassembles
//               the distance frame "<centena><dezena><unidade>#" into a
//               packed 12-bit BCD value.
//   clock       system clock, rising edge
//   reset       synchronous, active-high, clears every register
//   bus         rx_medida_7o1_if.slave (serial in, decoded results out)
// Parameters  : CLKS_POR_BIT clock cycles per bit (>= 4, even)
//               N_CNT        width of the bit-timing counter
// Revision    : 1.0 - initial release
// ============================================================================
module rx_medida_7o1 #(
    parameter int CLKS_POR_BIT = 434,
    parameter int N_CNT        = 9
) (
    input  wire logic        clock,
    input  wire logic        reset,
    rx_medida_7o1_if.slave   bus
);

    localparam logic [N_CNT-1:0] c_meio_m1 = N_CNT'(CLKS_POR_BIT / 2 - 1);
    localparam logic [N_CNT-1:0] c_bit_m1  = N_CNT'(CLKS_POR_BIT - 1);
    localparam logic [6:0]       c_cerquilha = 7'h23;

    typedef enum logic [2:0] {
        S_OCIOSO   = 3'd0,
        S_INICIO   = 3'd1,
        S_DADOS    = 3'd2,
        S_PARIDADE = 3'd3,
        S_PARADA   = 3'd4,
        S_ENTREGA  = 3'd5
    } rx_estado_t;

    typedef enum logic [2:0] {
        F_D0       = 3'd0,
        F_D1       = 3'd1,
        F_D2       = 3'd2,
        F_FIM      = 3'd3,
        F_DESCARTA = 3'd4
    } fr_estado_t;

    // ------------------------------------------------------------------
    // Input synchroniser: the line idles high, so reset to 1 to avoid a
    // false start bit coming out of reset.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.entrada_serial;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Character receiver
    // ------------------------------------------------------------------
    rx_estado_t       r_rx_estado;
    rx_estado_t       w_rx_prox;
    logic [N_CNT-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [6:0]       r_shift;
    logic             r_par;
    logic             r_stop;
    logic             w_fim_bit;
    logic             w_par_ok;
    logic             w_pronto;
    logic             w_erro_par;
    logic             w_erro_quadro;

    assign w_fim_bit = (r_cnt == c_bit_m1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_estado <= S_OCIOSO;
        end else begin
            r_rx_estado <= w_rx_prox;
        end
    end

    always_comb begin
        w_rx_prox = r_rx_estado;
        case (r_rx_estado)
            S_OCIOSO:   if (!r_sync2) w_rx_prox = S_INICIO;
            // Half a bit in: a line back high means a glitch, not a start.
            S_INICIO:   if (r_cnt == c_meio_m1)
                            w_rx_prox = r_sync2 ? S_OCIOSO : S_DADOS;
            S_DADOS:    if (w_fim_bit && (r_bit_idx == 3'd6))
                            w_rx_prox = S_PARIDADE;
            S_PARIDADE: if (w_fim_bit) w_rx_prox = S_PARADA;
            S_PARADA:   if (w_fim_bit) w_rx_prox = S_ENTREGA;
            // Go straight back to idle so the next start bit can arrive
            // during the remaining half of the stop bit.
            S_ENTREGA:  w_rx_prox = S_OCIOSO;
            default:    w_rx_prox = S_OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 7'd0;
            r_par     <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            case (r_rx_estado)
                S_OCIOSO: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                end
                S_INICIO: begin
                    r_cnt <= (r_cnt == c_meio_m1) ? '0 : r_cnt + N_CNT'(1);
                end
                S_DADOS: begin
                    if (w_fim_bit) begin
                        r_cnt     <= '0;
                        // LSB arrives first: shift in from the top.
                        r_shift   <= {r_sync2, r_shift[6:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + N_CNT'(1);
                    end
                end
                S_PARIDADE: begin
                    if (w_fim_bit) begin
                        r_cnt <= '0;
                        r_par <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + N_CNT'(1);
                    end
                end
                S_PARADA: begin
                    if (w_fim_bit) begin
                        r_cnt  <= '0;
                        r_stop <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + N_CNT'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Odd parity: data plus parity bit must hold an odd number of ones.
    // A parity failure outranks a framing failure.
    assign w_par_ok      = ^{r_shift, r_par};
    assign w_pronto      = (r_rx_estado == S_ENTREGA) &&  w_par_ok &&  r_stop;
    assign w_erro_par    = (r_rx_estado == S_ENTREGA) && !w_par_ok;
    assign w_erro_quadro = (r_rx_estado == S_ENTREGA) &&  w_par_ok && !r_stop;

    logic [6:0] r_dado;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dado <= 7'd0;
        end else if (w_pronto) begin
            r_dado <= r_shift;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembler, stepped by accepted characters and receive errors
    // ------------------------------------------------------------------
    fr_estado_t  r_fr_estado;
    fr_estado_t  w_fr_prox;
    logic        w_eh_digito;
    logic        w_eh_cerq;
    logic        w_carrega;
    logic        w_commit;
    logic        w_fmt;
    logic [11:0] r_staging;
    logic [11:0] r_medida;
    logic        r_medida_valida;
    logic        r_erro_formato;

    assign w_eh_digito = (r_shift >= 7'h30) && (r_shift <= 7'h39);
    assign w_eh_cerq   = (r_shift == c_cerquilha);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fr_estado <= F_D0;
        end else begin
            r_fr_estado <= w_fr_prox;
        end
    end

    always_comb begin
        w_fr_prox = r_fr_estado;
        w_carrega = 1'b0;
        w_commit  = 1'b0;
        w_fmt     = 1'b0;
        if (w_erro_par || w_erro_quadro) begin
            w_fr_prox = F_DESCARTA;
        end else if (w_pronto) begin
            case (r_fr_estado)
                F_D0, F_D1, F_D2: begin
                    if (w_eh_digito) begin
                        w_carrega = 1'b1;
                        case (r_fr_estado)
                            F_D0:    w_fr_prox = F_D1;
                            F_D1:    w_fr_prox = F_D2;
                            default: w_fr_prox = F_FIM;
                        endcase
                    end else if (w_eh_cerq) begin
                        // A short frame: '#' is still a valid resync point.
                        w_fmt     = 1'b1;
                        w_fr_prox = F_D0;
                    end else begin
                        w_fmt     = 1'b1;
                        w_fr_prox = F_DESCARTA;
                    end
                end
                F_FIM: begin
                    if (w_eh_cerq) begin
                        w_commit  = 1'b1;
                        w_fr_prox = F_D0;
                    end else begin
                        w_fmt     = 1'b1;
                        w_fr_prox = F_DESCARTA;
                    end
                end
                F_DESCARTA: if (w_eh_cerq) w_fr_prox = F_D0;
                default:    w_fr_prox = F_D0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_staging       <= 12'd0;
            r_medida        <= 12'd0;
            r_medida_valida <= 1'b0;
            r_erro_formato  <= 1'b0;
        end else begin
            // For an ASCII digit, char - 0x30 is simply its low nibble.
            if (w_carrega) begin
                case (r_fr_estado)
                    F_D0:    r_staging[11:8] <= r_shift[3:0];
                    F_D1:    r_staging[7:4]  <= r_shift[3:0];
                    default: r_staging[3:0]  <= r_shift[3:0];
                endcase
            end
            if (w_commit) begin
                r_medida <= r_staging;
            end
            r_medida_valida <= w_commit;
            r_erro_formato  <= w_fmt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dado_recebido = r_dado;
    assign bus.pronto        = w_pronto;
    assign bus.erro_paridade = w_erro_par;
    assign bus.erro_quadro   = w_erro_quadro;
    assign bus.medida        = r_medida;
    assign bus.medida_valida = r_medida_valida;
    assign bus.erro_formato  = r_erro_formato;
    assign bus.db_estado     = {r_rx_estado, 1'b0};

endmodule
`default_nettype wire
